// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB-to-RGBW converter: FIFO word layout,
// clock-count constants at 96 MHz and the serial-input state encoding.
package rgb_pkg;

   localparam int bnum_valid        = 31;
   localparam int bnum_stream_reset = 30;
   localparam int bnum_g_first      = 23;
   localparam int bnum_g_last       = 16;
   localparam int bnum_r_first      = 15;
   localparam int bnum_r_last       = 8;
   localparam int bnum_b_first      = 7;
   localparam int bnum_b_last       = 0;

   localparam logic [31:0] RESET_WORD = 32'hC000_0000;

   localparam int CLK_MHZ               = 96;
   localparam int BITS_PER_WORD         = 24;
   localparam int COUNTER_MAX_DEF       = 7800;
   localparam int GLITCH_CLKS_DEF       = 10;
   localparam int T1H_THRESH_DEF        = 58;
   localparam int HIGH_MAX_DEF          = 192;
   localparam int STREAM_RESET_CLKS_DEF = 4800;

   typedef enum logic [1:0] {
      S_SYNC,
      S_LOW,
      S_HIGH
   } sin_state_t;

   function automatic logic [31:0] data_word(input logic [23:0] grb);
      logic [31:0] w;
      w = '0;
      w[bnum_valid] = 1'b1;
      w[bnum_g_first:bnum_b_last] = grb;
      return w;
   endfunction

endpackage

// File: rtl/rgb_sin_sync.sv
// Two-flop synchroniser for the asynchronous serial line, plus a delay flop
// that yields registered one-clock rise and fall pulses.
module rgb_sin_sync (
   input  logic clk,
   input  logic rst,
   input  logic in_sig,
   output logic sig_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sig_d;

   // NOTE: every flop in a clocked block uses <= so all stages see the
   // pre-edge values and the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b0;
         sig_s <= 1'b0;
         sig_d <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta  <= in_sig;
         sig_s <= meta;
         sig_d <= sig_s;
         rise  <= sig_s & ~sig_d;
         fall  <= ~sig_s & sig_d;
      end
   end

endmodule

// File: rtl/rgb_sinp.sv
// WS2812B serial decoder: measures high-pulse widths, packs G-R-B bits into
// 24-bit words and writes status+colour words (or stream-reset words) to the FIFO.
module rgb_sinp
   import rgb_pkg::*;
#(
   parameter int COUNTER_MAX       = COUNTER_MAX_DEF,
   parameter int GLITCH_CLKS       = GLITCH_CLKS_DEF,
   parameter int T1H_THRESH        = T1H_THRESH_DEF,
   parameter int HIGH_MAX          = HIGH_MAX_DEF,
   parameter int STREAM_RESET_CLKS = STREAM_RESET_CLKS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_sig,
   input  logic        in_wr_fifo_full,
   output logic        out_wr_fifo_en,
   output logic [31:0] out_wr_fifo_data,
   output logic        out_overflow,
   output logic        out_frame_err
);

   localparam int CW = $clog2(COUNTER_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(COUNTER_MAX);
   localparam logic [CW-1:0] GL_CNT   = CW'(GLITCH_CLKS);
   localparam logic [CW-1:0] T1_CNT   = CW'(T1H_THRESH);
   localparam logic [CW-1:0] HM_CNT   = CW'(HIGH_MAX);
   localparam logic [CW-1:0] SR_CNT   = CW'(STREAM_RESET_CLKS);
   localparam logic [4:0]    WORD_LEN = 5'(BITS_PER_WORD);

   logic sig_s, rise, fall;

   rgb_sin_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .in_sig (in_sig),
      .sig_s  (sig_s),
      .rise   (rise),
      .fall   (fall)
   );

   sin_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] save_q, save_d;
   logic [4:0]    bitcnt_q, bitcnt_d;
   logic [23:0]   shift_q, shift_d;
   logic          rst_word, err_set, wr_due;
   logic [31:0]   wr_word;

   // NOTE: every signal driven here gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      save_d   = save_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      rst_word = 1'b0;
      err_set  = 1'b0;

      if (rise || fall)          cnt_d = {{(CW-1){1'b0}}, 1'b1};
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                       cnt_d = cnt_q + 1'b1;

      if (bitcnt_q == WORD_LEN) bitcnt_d = '0;

      case (state_q)
         S_SYNC: begin
            if (!sig_s && cnt_q == SR_CNT) begin
               rst_word = 1'b1;
               state_d  = S_LOW;
            end
         end
         S_LOW: begin
            if (cnt_q == SR_CNT) rst_word = 1'b1;
            if (rise) begin
               save_d  = cnt_q;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (cnt_q > HM_CNT) begin
               err_set  = 1'b1;
               bitcnt_d = '0;
               shift_d  = '0;
               state_d  = S_SYNC;
            end else if (fall) begin
               state_d = S_LOW;
               // A glitch resumes the low interval it interrupted.
               if (cnt_q < GL_CNT) begin
                  cnt_d = save_q;
               end else begin
                  shift_d  = {shift_q[22:0], (cnt_q >= T1_CNT)};
                  bitcnt_d = bitcnt_q + 5'd1;
               end
            end
         end
         default: state_d = S_SYNC;
      endcase

      if (rst_word) begin
         if (bitcnt_q != '0) err_set = 1'b1;
         bitcnt_d = '0;
         shift_d  = '0;
      end
   end

   assign wr_due  = rst_word | (bitcnt_q == WORD_LEN);
   assign wr_word = rst_word ? RESET_WORD : data_word(shift_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_SYNC;
         cnt_q            <= '0;
         save_q           <= '0;
         bitcnt_q         <= '0;
         shift_q          <= '0;
         out_wr_fifo_en   <= 1'b0;
         out_wr_fifo_data <= '0;
         out_overflow     <= 1'b0;
         out_frame_err    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         save_q         <= save_d;
         bitcnt_q       <= bitcnt_d;
         shift_q        <= shift_d;
         out_wr_fifo_en <= wr_due & ~in_wr_fifo_full;
         if (wr_due && !in_wr_fifo_full) out_wr_fifo_data <= wr_word;
         if (wr_due && in_wr_fifo_full)  out_overflow     <= 1'b1;
         if (err_set)                    out_frame_err    <= 1'b1;
      end
   end

endmodule
